motor_cmd_sequencer: RTL and testbench
======================================

// Module: motor_cmd_sequencer
// PURPOSE
//  Sits between the navigation logic and the dual-motor PWM pulse generator. Arbitrates motor
//  commands from two requesters (NAV, AVOID; AVOID has priority) and ramps each motor one
//  power level per refresh frame. Forces a neutral dwell before any direction reversal.
//  Falls back to neutral if commands stop arriving. Drives MC1/MC2 in the 5-bit code
//  {power[4:2], dir[1:0]}: dir 00=FWD, 01=NEUTRAL, 10=REV, 11 treated as NEUTRAL.
// PARAMETERS
//  REFRESH_CYCLES  1200000  clocks per frame (12 ms @ 100 MHz); matches the PWM refresh
//  NEUTRAL_FRAMES  4        frames a motor must sit at neutral before leaving it
//  AVOID_HOLD      25       frames NAV stays locked out after the last AVOID accept
//  CMD_TIMEOUT     42       frames with no accepted command before targets forced to neutral
// PORTS
//  CLK           in   1   system clock
//  RST_N         in   1   asynchronous active-low reset
//  NAV_VALID     in   1   NAV command present
//  NAV_MC1       in   5   NAV target, left motor
//  NAV_MC2       in   5   NAV target, right motor
//  NAV_ACK       out  1   1-cycle pulse: NAV command accepted
//  AVOID_VALID   in   1   AVOID command present
//  AVOID_MC1     in   5   AVOID target, left motor
//  AVOID_MC2     in   5   AVOID target, right motor
//  AVOID_ACK     out  1   1-cycle pulse: AVOID command accepted
//  MC1           out  5   ramped left-motor command to PWM generator
//  MC2           out  5   ramped right-motor command to PWM generator
//  FRAME         out  1   1-cycle pulse, high the cycle MC1/MC2 take a new frame value
//  AVOID_ACTIVE  out  1   NAV lockout in force
//  TIMEOUT       out  1   watchdog fired; high until the next accept
// BEHAVIOUR
//  Reset: frame count 0, speeds 0, targets 0, dwell 0, lock/watchdog counters 0.
//   MC1=MC2=5'b00001; all flag/ACK outputs 0.
//  Frame: count runs 0..REFRESH_CYCLES-1 and wraps. Internal tick when count==REFRESH_CYCLES-1.
//   At the tick edge, speeds/counters step. MC1/MC2 and FRAME are registered one cycle later.
//  Speed level s per motor is signed, -8..+8. Command decode: FWD p -> +(p+1),
//   REV p -> -(p+1), NEUTRAL/11 -> 0. Encode: s=0 -> 00001; s>0 -> {s-1,00}; s<0 -> {-s-1,10}.
//  Arbitration, every cycle:
//   AVOID_VALID -> accept AVOID.
//   else NAV_VALID && !AVOID_ACTIVE -> accept NAV. A blocked NAV gets no ACK.
//   An accept loads both targets, clears watchdog and TIMEOUT, and pulses the ACK next cycle.
//  AVOID accept: lock counter := AVOID_HOLD, AVOID_ACTIVE=1. Counter decrements on each tick;
//   AVOID_ACTIVE drops when it reaches 0.
//  Watchdog: +1 per tick with no accept. On reaching CMD_TIMEOUT: targets := 0, TIMEOUT=1,
//   counter saturates. An accept in the same cycle as that tick wins (no timeout).
//  Per-motor FSM, evaluated on tick using pre-edge target t:
//   DRIVE (s!=0):
//    t same sign as s and t!=s -> s moves 1 toward t.
//    t==0 or opposite sign -> s moves 1 toward 0.
//    Entering s=0 -> HOLD with dwell:=0.
//   HOLD (s=0): dwell +1 per tick, saturating at NEUTRAL_FRAMES.
//    If t!=0 and dwell>=NEUTRAL_FRAMES (pre-increment value) -> s := sign(t)*1, go to DRIVE.
//  Reversal therefore takes |s| down-steps, then NEUTRAL_FRAMES dwell, then up-steps.
//   A magnitude change is never more than 1 level/frame.
//  A command accepted on the tick cycle affects the next tick only.
//  Motors are independent; each has its own FSM, s, and dwell.
//  Reset mid-operation: async return to reset values; the output is neutral immediately.
//  Arithmetic: s is 5-bit two's complement; the frame counter is ceil(log2(REFRESH_CYCLES)) bits.
// TESTING (REFRESH_CYCLES=16, NEUTRAL_FRAMES=2, AVOID_HOLD=3, CMD_TIMEOUT=6)
//  1 Reset, NAV MC1=11100 (FWD p7) 1 clk -> NAV_ACK next clk. MC1 stays 00001 for 2 frames,
//    then 00000,00100,...,11100 one per FRAME (8 frames).
//  2 From MC1=11100, NAV MC1=00010 (REV p0) -> 7 down-steps to 00000, 00001 for 2 frames,
//    then 00010; no FWD->REV frame skipping neutral.
//  3 AVOID and NAV valid same cycle -> AVOID_ACK only, AVOID_ACTIVE=1. NAV rejected for 3 ticks;
//    NAV accepted after AVOID_ACTIVE falls.
//  4 No commands for 6 frames while MC2 at +3 (01000) -> TIMEOUT=1, MC2 ramps
//    01000->00100->00000->00001. A new accept clears TIMEOUT.
//  5 RST_N low mid-frame with MC1=10000 -> MC1=00001 and FRAME=0 asynchronously.
//    Frame count restarts at 0.
//  6 Accept on the tick cycle -> that FRAME reflects the old target; the next FRAME steps
//    toward the new one.

Source files
------------

// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: arbitrates NAV/AVOID requests and ramps both
// motors one power level per refresh frame, dwelling at neutral on reversal.
module motor_ramp #(
  parameter int unsigned NEUTRAL_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic signed [4:0] tgt,
  output logic signed [4:0] spd
);

  localparam int unsigned DW = $clog2(NEUTRAL_FRAMES + 1);
  localparam logic [DW-1:0] NF = DW'(NEUTRAL_FRAMES);

  typedef enum logic {
    HOLD,
    DRIVE
  } state_e;

  state_e            st_q, st_d;
  logic signed [4:0] s_q, s_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic              same_sign;

  always_comb begin
    st_d      = st_q;
    s_d       = s_q;
    dwell_d   = dwell_q;
    same_sign = (tgt[4] == s_q[4]) && (tgt != 5'sd0);
    if (tick) begin
      unique case (st_q)
        HOLD: begin
          if (tgt != 5'sd0 && dwell_q >= NF) begin
            s_d  = tgt[4] ? -5'sd1 : 5'sd1;
            st_d = DRIVE;
          end else if (dwell_q < NF) begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        DRIVE: begin
          if (same_sign) begin
            if (tgt > s_q) s_d = s_q + 5'sd1;
            else if (tgt < s_q) s_d = s_q - 5'sd1;
          end else begin
            // Target neutral or reversed: bleed off toward zero first
            s_d = s_q[4] ? s_q + 5'sd1 : s_q - 5'sd1;
          end
          if (s_d == 5'sd0) begin
            st_d    = HOLD;
            dwell_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= HOLD;
      s_q     <= 5'sd0;
      dwell_q <= '0;
    end else begin
      st_q    <= st_d;
      s_q     <= s_d;
      dwell_q <= dwell_d;
    end
  end

  assign spd = s_q;

endmodule

module motor_cmd_sequencer #(
  parameter int unsigned REFRESH_CYCLES = 1200000,
  parameter int unsigned NEUTRAL_FRAMES = 4,
  parameter int unsigned AVOID_HOLD     = 25,
  parameter int unsigned CMD_TIMEOUT    = 42
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       NAV_VALID,
  input  logic [4:0] NAV_MC1,
  input  logic [4:0] NAV_MC2,
  output logic       NAV_ACK,
  input  logic       AVOID_VALID,
  input  logic [4:0] AVOID_MC1,
  input  logic [4:0] AVOID_MC2,
  output logic       AVOID_ACK,
  output logic [4:0] MC1,
  output logic [4:0] MC2,
  output logic       FRAME,
  output logic       AVOID_ACTIVE,
  output logic       TIMEOUT
);

  localparam int unsigned CW =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned LW = $clog2(AVOID_HOLD + 1);
  localparam int unsigned WW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_V  = LW'(AVOID_HOLD);
  localparam logic [WW-1:0] WD_MAX  = WW'(CMD_TIMEOUT);

  function automatic logic signed [4:0] dec_cmd(input logic [4:0] c);
    logic signed [4:0] mag;
    mag = $signed({2'b00, c[4:2]}) + 5'sd1;
    dec_cmd = 5'sd0;
    unique case (1'b1)
      (c[1:0] == 2'b00): dec_cmd = mag;
      (c[1:0] == 2'b10): dec_cmd = -mag;
      default:           dec_cmd = 5'sd0;
    endcase
  endfunction

  // Negative levels: -s-1 is simply the bitwise inverse
  function automatic logic [4:0] enc_lvl(input logic signed [4:0] s);
    logic [2:0] p;
    p = s[4] ? ~s[2:0] : s[2:0] - 3'd1;
    if (s == 5'sd0) enc_lvl = 5'b00001;
    else            enc_lvl = {p, s[4], 1'b0};
  endfunction

  logic [CW-1:0]     cnt_q, cnt_d;
  logic signed [4:0] t1_q, t1_d, t2_q, t2_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              to_q, to_d;
  logic              act_q, act_d;
  logic              nav_ack_q, avoid_ack_q;
  logic              tick_dly_q, frame_q;
  logic [4:0]        mc1_q, mc1_d, mc2_q, mc2_d;
  logic signed [4:0] s1, s2;
  logic              tick, acc_nav, acc_avoid;

  motor_ramp #(.NEUTRAL_FRAMES(NEUTRAL_FRAMES)) u_left (
    .clk   (CLK),
    .rst_n (RST_N),
    .tick  (tick),
    .tgt   (t1_q),
    .spd   (s1)
  );

  motor_ramp #(.NEUTRAL_FRAMES(NEUTRAL_FRAMES)) u_right (
    .clk   (CLK),
    .rst_n (RST_N),
    .tick  (tick),
    .tgt   (t2_q),
    .spd   (s2)
  );

  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    acc_avoid = AVOID_VALID;
    acc_nav   = !AVOID_VALID && NAV_VALID && !act_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    t1_d      = t1_q;
    t2_d      = t2_q;
    lock_d    = lock_q;
    wd_d      = wd_q;
    to_d      = to_q;
    if (tick && lock_q != '0) lock_d = lock_q - 1'b1;
    if (acc_avoid) begin
      t1_d   = dec_cmd(AVOID_MC1);
      t2_d   = dec_cmd(AVOID_MC2);
      lock_d = LOCK_V;
    end else if (acc_nav) begin
      t1_d = dec_cmd(NAV_MC1);
      t2_d = dec_cmd(NAV_MC2);
    end
    // A same-cycle accept beats the watchdog
    if (acc_avoid || acc_nav) begin
      wd_d = '0;
      to_d = 1'b0;
    end else if (tick && wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
      if (wd_d == WD_MAX) begin
        t1_d = 5'sd0;
        t2_d = 5'sd0;
        to_d = 1'b1;
      end
    end
    act_d = (lock_d != '0);
    mc1_d = enc_lvl(s1);
    mc2_d = enc_lvl(s2);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= '0;
      t1_q        <= 5'sd0;
      t2_q        <= 5'sd0;
      lock_q      <= '0;
      wd_q        <= '0;
      to_q        <= 1'b0;
      act_q       <= 1'b0;
      nav_ack_q   <= 1'b0;
      avoid_ack_q <= 1'b0;
      tick_dly_q  <= 1'b0;
      frame_q     <= 1'b0;
      mc1_q       <= 5'b00001;
      mc2_q       <= 5'b00001;
    end else begin
      cnt_q       <= cnt_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      lock_q      <= lock_d;
      wd_q        <= wd_d;
      to_q        <= to_d;
      act_q       <= act_d;
      nav_ack_q   <= acc_nav;
      avoid_ack_q <= acc_avoid;
      tick_dly_q  <= tick;
      frame_q     <= tick_dly_q;
      mc1_q       <= mc1_d;
      mc2_q       <= mc2_d;
    end
  end

  assign NAV_ACK      = nav_ack_q;
  assign AVOID_ACK    = avoid_ack_q;
  assign MC1          = mc1_q;
  assign MC2          = mc2_q;
  assign FRAME        = frame_q;
  assign AVOID_ACTIVE = act_q;
  assign TIMEOUT      = to_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: frame-level reference model feeds a
// scoreboard that a free-running monitor drains every cycle and FRAME.
module tb_motor_cmd_sequencer;

  localparam int RC = 16;
  localparam int NF = 2;
  localparam int AH = 3;
  localparam int CT = 6;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       NAV_VALID = 1'b0;
  logic [4:0] NAV_MC1 = '0;
  logic [4:0] NAV_MC2 = '0;
  logic       NAV_ACK;
  logic       AVOID_VALID = 1'b0;
  logic [4:0] AVOID_MC1 = '0;
  logic [4:0] AVOID_MC2 = '0;
  logic       AVOID_ACK;
  logic [4:0] MC1, MC2;
  logic       FRAME, AVOID_ACTIVE, TIMEOUT;

  always #5 CLK = ~CLK;

  motor_cmd_sequencer #(
    .REFRESH_CYCLES (RC),
    .NEUTRAL_FRAMES (NF),
    .AVOID_HOLD     (AH),
    .CMD_TIMEOUT    (CT)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .NAV_VALID    (NAV_VALID),
    .NAV_MC1      (NAV_MC1),
    .NAV_MC2      (NAV_MC2),
    .NAV_ACK      (NAV_ACK),
    .AVOID_VALID  (AVOID_VALID),
    .AVOID_MC1    (AVOID_MC1),
    .AVOID_MC2    (AVOID_MC2),
    .AVOID_ACK    (AVOID_ACK),
    .MC1          (MC1),
    .MC2          (MC2),
    .FRAME        (FRAME),
    .AVOID_ACTIVE (AVOID_ACTIVE),
    .TIMEOUT      (TIMEOUT)
  );

  typedef struct packed {
    logic       nav_ack;
    logic       avoid_ack;
    logic       active;
    logic       timeout;
    logic       frame;
    logic [4:0] mc1;
    logic [4:0] mc2;
  } obs_t;

  obs_t       exp_q[$];
  logic [9:0] frm_q[$];
  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 0;

  int m_n;
  int m_s[2];
  int m_t[2];
  int m_nf[2];
  int m_lock;
  int m_idle;
  bit m_to;
  bit m_prev_tick;

  function automatic int sgn(input int x);
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  function automatic int dec_cmd(input logic [4:0] c);
    int mag;
    mag = int'(c[4:2]) + 1;
    if (c[1:0] == 2'b00) return mag;
    if (c[1:0] == 2'b10) return -mag;
    return 0;
  endfunction

  function automatic logic [4:0] enc_lvl(input int s);
    logic [2:0] p;
    if (s == 0) return 5'b00001;
    p = 3'(((s > 0) ? s : -s) - 1);
    return {p, (s < 0), 1'b0};
  endfunction

  function automatic void model_reset();
    m_n = 0;
    m_s = '{0, 0};
    m_t = '{0, 0};
    m_nf = '{0, 0};
    m_lock = 0;
    m_idle = 0;
    m_to = 0;
    m_prev_tick = 0;
    exp_q.delete();
    frm_q.delete();
  endfunction

  // Predicts what the outputs show after the next clock edge
  function automatic void model_step(
    input bit nv, input logic [4:0] n1, input logic [4:0] n2,
    input bit av, input logic [4:0] a1, input logic [4:0] a2);
    obs_t o;
    bit   tick, acc_n;
    int   goal, s0;
    m_n++;
    tick  = (m_n % RC) == 0;
    o.mc1 = enc_lvl(m_s[0]);
    o.mc2 = enc_lvl(m_s[1]);
    o.frame = m_prev_tick;
    acc_n = !av && nv && (m_lock == 0);
    if (tick) begin
      for (int i = 0; i < 2; i++) begin
        s0 = m_s[i];
        if (s0 == 0)
          goal = (m_t[i] != 0 && m_nf[i] >= NF) ? sgn(m_t[i]) : 0;
        else
          goal = (m_t[i] * s0 > 0) ? m_t[i] : 0;
        m_s[i] = s0 + sgn(goal - s0);
        if (m_s[i] == 0) m_nf[i] = (s0 == 0) ? m_nf[i] + 1 : 0;
      end
      if (m_lock > 0) m_lock--;
      if (!av && !acc_n && m_idle < CT) begin
        m_idle++;
        if (m_idle == CT) begin
          m_t = '{0, 0};
          m_to = 1;
        end
      end
      frm_q.push_back({enc_lvl(m_s[0]), enc_lvl(m_s[1])});
    end
    if (av) begin
      m_t[0] = dec_cmd(a1);
      m_t[1] = dec_cmd(a2);
      m_lock = AH;
    end else if (acc_n) begin
      m_t[0] = dec_cmd(n1);
      m_t[1] = dec_cmd(n2);
    end
    if (av || acc_n) begin
      m_idle = 0;
      m_to = 0;
    end
    o.nav_ack   = acc_n;
    o.avoid_ack = av;
    o.active    = (m_lock != 0);
    o.timeout   = m_to;
    m_prev_tick = tick;
    exp_q.push_back(o);
  endfunction

  initial forever begin
    obs_t       got, e;
    logic [9:0] ef;
    @(posedge CLK);
    #1;
    if (mon_en) begin
      got = {NAV_ACK, AVOID_ACK, AVOID_ACTIVE, TIMEOUT, FRAME, MC1, MC2};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL obs @%0t: got %b, required an expected entry", $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL obs @%0t: got ack=%b%b act=%b to=%b frm=%b mc=%b/%b, required ack=%b%b act=%b to=%b frm=%b mc=%b/%b",
            $time, got.nav_ack, got.avoid_ack, got.active, got.timeout, got.frame, got.mc1, got.mc2,
            e.nav_ack, e.avoid_ack, e.active, e.timeout, e.frame, e.mc1, e.mc2);
        end
      end
      if (FRAME === 1'b1) begin
        tests++;
        if (frm_q.size() == 0) begin
          fails++;
          $display("FAIL frame @%0t: got FRAME with mc=%b/%b, required no FRAME", $time, MC1, MC2);
        end else begin
          ef = frm_q.pop_front();
          if ({MC1, MC2} !== ef) begin
            fails++;
            $display("FAIL frame @%0t: got mc=%b/%b, required %b/%b", $time, MC1, MC2, ef[9:5], ef[4:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b", nm, got, exp);
    end
  endtask

  task automatic step(
    input bit nv, input logic [4:0] n1, input logic [4:0] n2,
    input bit av, input logic [4:0] a1, input logic [4:0] a2);
    NAV_VALID   = nv;
    NAV_MC1     = n1;
    NAV_MC2     = n2;
    AVOID_VALID = av;
    AVOID_MC1   = a1;
    AVOID_MC2   = a2;
    model_step(nv, n1, n2, av, a1, a2);
    @(negedge CLK);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic keep_nav(input logic [4:0] m1, input logic [4:0] m2, input int frames);
    for (int c = 0; c < frames * RC; c++) begin
      if (c % 32 == 0) step(1, m1, m2, 0, '0, '0);
      else step(0, '0, '0, 0, '0, '0);
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    NAV_VALID = 0;
    AVOID_VALID = 0;
    RST_N = 0;
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    RST_N = 1;
    mon_en = 1;
  endtask

  initial begin
    int len, mode;
    bit nv, av;
    repeat (3) @(negedge CLK);
    chk("rst_mc1", MC1, 5'b00001);
    chk("rst_mc2", MC2, 5'b00001);
    chk("rst_flags", {1'b0, NAV_ACK, AVOID_ACK, FRAME, AVOID_ACTIVE | TIMEOUT}, 5'b00000);
    model_reset();
    RST_N = 1;
    mon_en = 1;

    keep_nav(5'b11100, 5'b00001, 13);
    chk("ramp_up_mc1", MC1, 5'b11100);
    keep_nav(5'b00010, 5'b00001, 13);
    chk("reverse_mc1", MC1, 5'b00010);

    step(1, 5'b00001, 5'b01000, 1, 5'b00001, 5'b01000);
    for (int c = 0; c < 5 * RC; c++) begin
      if (c % 8 == 0) step(1, 5'b00001, 5'b01000, 0, '0, '0);
      else idle(1);
    end

    step(1, 5'b00001, 5'b01000, 0, '0, '0);
    idle(12 * RC);
    chk("timeout_flag", 5'(TIMEOUT), 5'd1);
    chk("timeout_mc2", MC2, 5'b00001);
    step(1, 5'b00001, 5'b00001, 0, '0, '0);

    while (((m_n + 1) % RC) != 0) idle(1);
    step(1, 5'b10000, 5'b00110, 0, '0, '0);
    idle(3 * RC);

    for (int seg = 0; seg < 40; seg++) begin
      mode = $urandom_range(0, 3);
      len = (mode == 0) ? $urandom_range(60, 200) : $urandom_range(16, 120);
      for (int c = 0; c < len; c++) begin
        nv = (mode == 3) ? ($urandom_range(0, 3) == 0)
                         : (mode >= 1 && $urandom_range(0, 30) == 0);
        av = (mode >= 2) && ($urandom_range(0, 40) == 0);
        step(nv, 5'($urandom), 5'($urandom), av, 5'($urandom), 5'($urandom));
      end
    end

    do_reset();
    keep_nav(5'b10000, 5'b00001, 9);
    chk("pre_rst_mc1", MC1, 5'b10000);
    while ((m_n % RC) != 0) idle(1);
    mon_en = 0;
    @(posedge CLK);
    #2;
    chk("pre_rst_frame", 5'(FRAME), 5'd1);
    #1;
    RST_N = 0;
    #1;
    chk("async_mc1", MC1, 5'b00001);
    chk("async_mc2", MC2, 5'b00001);
    chk("async_frame", 5'(FRAME), 5'd0);
    @(negedge CLK);
    model_reset();
    RST_N = 1;
    mon_en = 1;
    idle(2 * RC + 4);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
    end
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
